// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared types, defaults and saturation helper for the nn datapath stages
// Purpose: state encoding of the dense layer FSM, default fixed-point format
//          constants and a saturate-to-width helper reused by the softmax side.
// Ports:   none (package)
package nn_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ACC_INIT,
      MAC,
      WRITE,
      DONE
   } state_t;

   localparam int DEF_WIDTH             = 16;
   localparam int DEF_FIXED_POINT_INDEX = 8;

   // Working width of the saturation helper; callers sign-extend into it and
   // truncate the result back down to their own word width.
   localparam int SAT_W = 64;

   // Clamp a signed value to the range of a signed word of 'width' bits.
   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] value,
      input int                      width
   );
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (width - 1));
      if (value > max_v) begin
         return max_v;
      end else if (value < min_v) begin
         return min_v;
      end
      return value;
   endfunction

endpackage

// File: rtl/fxp_mac.sv
// rtl/fxp_mac.sv - signed fixed-point multiply-accumulate unit
// Purpose: full-precision accumulator that can be preloaded with a bias
//          (aligned to the product's fraction position) and then accumulates
//          a*b once per enabled cycle.
// Ports:   clk     - clock
//          reset   - asynchronous active-low reset, clears acc
//          load    - preload acc with bias << FRAC (bias 0 acts as clear)
//          bias    - signed bias word
//          acc_en  - add a*b to acc this cycle
//          a, b    - signed operands
//          acc     - signed accumulator value
module fxp_mac
   import nn_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FIXED_POINT_INDEX,
   parameter int ACC_W = 2 * DEF_WIDTH + 7
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [WIDTH-1:0]        bias,
   input  logic                    acc_en,
   input  logic [WIDTH-1:0]        a,
   input  logic [WIDTH-1:0]        b,
   output logic signed [ACC_W-1:0] acc
);

   logic signed [2*WIDTH-1:0] product;
   logic signed [ACC_W-1:0]   bias_ext;

   assign product  = $signed(a) * $signed(b);
   // Bias carries FRAC fraction bits while products carry 2*FRAC.
   assign bias_ext = ACC_W'($signed(bias)) <<< FRAC;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc <= '0;
      end else if (load) begin
         acc <= bias_ext;
      end else if (acc_en) begin
         acc <= acc + ACC_W'(product);
      end
   end

endmodule

// File: rtl/dense_layer.sv
// rtl/dense_layer.sv - fully connected layer, one MAC, weights streamed from memory
// Purpose: computes output[j] = sat((bias[j] << F + sum_k in[k]*w[j*IN_DIM+k]) >>> F)
//          for all j, reading one weight per cycle from a 1-cycle-latency memory.
// Ports:   clk          - clock
//          reset        - asynchronous active-low reset
//          start        - begin one evaluation (ignored while busy)
//          input_data   - activation vector, captured on start
//          bias         - per-output bias, captured on start
//          weight_rd_en - weight memory read strobe
//          weight_addr  - weight address, row-major j*IN_DIM+k
//          weight_data  - weight returned one cycle after the address
//          output_data  - saturated logits, held until overwritten
//          busy         - evaluation in progress
//          done         - one-cycle completion pulse
module dense_layer
   import nn_pkg::*;
#(
   parameter int WIDTH             = DEF_WIDTH,
   parameter int FIXED_POINT_INDEX = DEF_FIXED_POINT_INDEX,
   parameter int IN_DIM            = 64,
   parameter int OUT_DIM           = 10,
   localparam int AW               = (IN_DIM * OUT_DIM > 1) ? $clog2(IN_DIM * OUT_DIM) : 1
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            start,
   input  logic [IN_DIM-1:0][WIDTH-1:0]    input_data,
   input  logic [OUT_DIM-1:0][WIDTH-1:0]   bias,
   output logic                            weight_rd_en,
   output logic [AW-1:0]                   weight_addr,
   input  logic [WIDTH-1:0]                weight_data,
   output logic [OUT_DIM-1:0][WIDTH-1:0]   output_data,
   output logic                            busy,
   output logic                            done
);

   localparam int KW    = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
   localparam int JW    = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
   // Room for IN_DIM full-precision products plus the shifted bias.
   localparam int ACC_W = 2 * WIDTH + $clog2(IN_DIM) + 1;

   localparam logic [KW-1:0] K_LAST = KW'(IN_DIM - 1);
   localparam logic [JW-1:0] J_LAST = JW'(OUT_DIM - 1);

   state_t state;
   state_t state_next;

   logic [KW-1:0]                 k;
   logic [JW-1:0]                 j;
   logic [IN_DIM-1:0][WIDTH-1:0]  in_reg;
   logic [OUT_DIM-1:0][WIDTH-1:0] bias_reg;
   logic [AW-1:0]                 row_base;
   logic                          mac_load;
   logic                          mac_en;
   logic signed [ACC_W-1:0]       acc;

   assign row_base = AW'(j) * AW'(IN_DIM);

   fxp_mac #(
      .WIDTH (WIDTH),
      .FRAC  (FIXED_POINT_INDEX),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .load   (mac_load),
      .bias   (bias_reg[j]),
      .acc_en (mac_en),
      .a      (in_reg[k]),
      .b      (weight_data),
      .acc    (acc)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next   = state;
      busy         = 1'b1;
      done         = 1'b0;
      weight_rd_en = 1'b0;
      weight_addr  = '0;
      mac_load     = 1'b0;
      mac_en       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = ACC_INIT;
            end
         end
         ACC_INIT: begin
            mac_load     = 1'b1;
            weight_rd_en = 1'b1;
            weight_addr  = row_base;
            state_next   = MAC;
         end
         MAC: begin
            // weight_data here answers the address issued last cycle (index k);
            // prefetch k+1 so one product lands every cycle.
            mac_en = 1'b1;
            if (k == K_LAST) begin
               state_next = WRITE;
            end else begin
               weight_rd_en = 1'b1;
               weight_addr  = row_base + AW'(k) + AW'(1);
            end
         end
         WRITE: begin
            state_next = (j == J_LAST) ? DONE : ACC_INIT;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         j           <= '0;
         k           <= '0;
         in_reg      <= '0;
         bias_reg    <= '0;
         output_data <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  in_reg   <= input_data;
                  bias_reg <= bias;
                  j        <= '0;
               end
            end
            ACC_INIT: begin
               k <= '0;
            end
            MAC: begin
               if (k != K_LAST) begin
                  k <= k + KW'(1);
               end
            end
            WRITE: begin
               // Arithmetic shift floors toward minus infinity before clamping.
               output_data[j] <= WIDTH'(saturate(64'(acc >>> FIXED_POINT_INDEX), WIDTH));
               if (j != J_LAST) begin
                  j <= j + JW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
